// File: rtl/cae_disp_ctrl_if.sv
// cae_disp_ctrl_if: dispatch, core and CSR signal bundle between host/cores (master) and cae_disp_ctrl (slave)
// dispatch: inst/aeg access in, exceptions/idle/stall/read data out
// cores: core_run/aeg_flat out, core_done/core_gvt in
// csr: read strobe/address in, ack/data out
interface cae_disp_ctrl_if #(
   parameter int NUM_AEG   = 8,
   parameter int NUM_CORES = 4,
   parameter int GVT_W     = 16
);
   logic                       disp_inst_vld;
   logic [4:0]                 disp_inst;
   logic [17:0]                disp_aeg_idx;
   logic                       disp_aeg_rd;
   logic                       disp_aeg_wr;
   logic [63:0]                disp_aeg_wr_data;
   logic [17:0]                disp_aeg_cnt;
   logic [15:0]                disp_exception;
   logic                       disp_idle;
   logic                       disp_stall;
   logic                       disp_rtn_data_vld;
   logic [63:0]                disp_rtn_data;
   logic [NUM_CORES-1:0]       core_run;
   logic [NUM_CORES-1:0]       core_done;
   logic [NUM_CORES*GVT_W-1:0] core_gvt;
   logic [NUM_AEG*64-1:0]      aeg_flat;
   logic                       csr_rd_vld;
   logic [15:0]                csr_address;
   logic                       csr_rd_ack;
   logic [63:0]                csr_rd_data;
   modport master (
      output disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr, disp_aeg_wr_data,
             core_done, core_gvt, csr_rd_vld, csr_address,
      input  disp_aeg_cnt, disp_exception, disp_idle, disp_stall, disp_rtn_data_vld, disp_rtn_data,
             core_run, aeg_flat, csr_rd_ack, csr_rd_data
   );
   modport slave (
      input  disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr, disp_aeg_wr_data,
             core_done, core_gvt, csr_rd_vld, csr_address,
      output disp_aeg_cnt, disp_exception, disp_idle, disp_stall, disp_rtn_data_vld, disp_rtn_data,
             core_run, aeg_flat, csr_rd_ack, csr_rd_data
   );
endinterface

// File: rtl/cae_disp_ctrl.sv
// cae_disp_ctrl: dispatch front end owning AEGs, launching cores and reducing their GVTs to a global minimum
// ports: clk, i_reset (async, active-high), bus (cae_disp_ctrl_if.slave: dispatch, core and CSR signals)
module cae_disp_ctrl #(
   parameter int NUM_AEG   = 8,
   parameter int AEG_IDX_W = 3,
   parameter int NUM_CORES = 4,
   parameter int GVT_W     = 16
) (
   input logic          clk,
   input logic          i_reset,
   cae_disp_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LAUNCH, RUNNING, FINISH} state_t;
   state_t                         state_q, state_d;
   logic [NUM_AEG-1:0][63:0]       aeg_q, aeg_d;
   logic [NUM_CORES-1:0]           mask_q, mask_d, done_q, done_d;
   logic [NUM_CORES-1:0][GVT_W-1:0] gvt_q, gvt_d;
   logic [31:0]                    limit_q, limit_d, cnt_q, cnt_d, cnt_inc;
   logic [4:0]                     exc_q, exc_d;
   logic                           rtn_vld_q, csr_ack_q;
   logic [63:0]                    rtn_data_q, rtn_data_d, csr_data_q, csr_data_d;
   logic [GVT_W-1:0]               gvt_min;
   logic [AEG_IDX_W-1:0]           aidx;
   logic                           start, abort, idx_ok;
   always_comb begin
      start   = bus.disp_inst_vld & (bus.disp_inst == 5'd0);
      abort   = bus.disp_inst_vld & (bus.disp_inst == 5'd1);
      idx_ok  = bus.disp_aeg_idx < 18'(NUM_AEG);
      aidx    = bus.disp_aeg_idx[AEG_IDX_W-1:0];
      cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
      gvt_min = '1;
      for (int i = 0; i < NUM_CORES; i++)
         if (done_q[i] && gvt_q[i] < gvt_min) gvt_min = gvt_q[i];
      state_d = state_q;
      aeg_d   = aeg_q;
      mask_d  = mask_q;
      limit_d = limit_q;
      done_d  = done_q;
      gvt_d   = gvt_q;
      cnt_d   = cnt_q;
      exc_d   = '0;
      exc_d[0] = bus.disp_inst_vld & (bus.disp_inst > 5'd1);
      exc_d[1] = (bus.disp_aeg_rd | bus.disp_aeg_wr) & ~idx_ok;
      exc_d[2] = bus.disp_aeg_wr & (state_q != IDLE);
      if (bus.disp_aeg_wr && idx_ok && state_q == IDLE) aeg_d[aidx] = bus.disp_aeg_wr_data;
      rtn_data_d = (bus.disp_aeg_rd && idx_ok) ? aeg_q[aidx] : '0;
      csr_data_d = !bus.csr_rd_vld         ? '0 :
                   bus.csr_address == 16'h0 ? {30'd0, state_q, 32'(done_q)} :
                   bus.csr_address == 16'h1 ? aeg_q[0] :
                   bus.csr_address == 16'h2 ? {32'd0, cnt_q} : '0;
      case (state_q)
         IDLE: if (start) state_d = LAUNCH;
         LAUNCH: begin
            // mask/limit sampled here so a write issued alongside start is seen
            mask_d  = aeg_q[1][NUM_CORES-1:0];
            limit_d = aeg_q[2][31:0];
            done_d  = '0;
            cnt_d   = '0;
            state_d = (mask_d == '0) ? FINISH : RUNNING;
         end
         RUNNING: begin
            cnt_d = cnt_inc;
            for (int i = 0; i < NUM_CORES; i++)
               if (bus.core_done[i] && mask_q[i] && !done_q[i]) begin
                  done_d[i] = 1'b1;
                  gvt_d[i]  = bus.core_gvt[i*GVT_W +: GVT_W];
               end
            // abort beats completion, completion beats timeout
            if (abort) begin
               state_d  = FINISH;
               exc_d[4] = 1'b1;
            end else if (done_d == mask_q) state_d = FINISH;
            else if (limit_q != '0 && cnt_inc == limit_q) begin
               state_d  = FINISH;
               exc_d[3] = 1'b1;
            end
         end
         FINISH: begin
            aeg_d[0] = (mask_q == '0) ? '0 : 64'(gvt_min);
            state_d  = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or posedge i_reset)
      if (i_reset) begin
         state_q    <= IDLE;
         aeg_q      <= '0;
         mask_q     <= '0;
         limit_q    <= '0;
         done_q     <= '0;
         gvt_q      <= '0;
         cnt_q      <= '0;
         exc_q      <= '0;
         rtn_vld_q  <= 1'b0;
         rtn_data_q <= '0;
         csr_ack_q  <= 1'b0;
         csr_data_q <= '0;
      end else begin
         state_q    <= state_d;
         aeg_q      <= aeg_d;
         mask_q     <= mask_d;
         limit_q    <= limit_d;
         done_q     <= done_d;
         gvt_q      <= gvt_d;
         cnt_q      <= cnt_d;
         exc_q      <= exc_d;
         rtn_vld_q  <= bus.disp_aeg_rd;
         rtn_data_q <= rtn_data_d;
         csr_ack_q  <= bus.csr_rd_vld;
         csr_data_q <= csr_data_d;
      end
   assign bus.disp_aeg_cnt      = 18'(NUM_AEG);
   assign bus.disp_exception    = {11'd0, exc_q};
   assign bus.disp_idle         = (state_q == IDLE) & ~start;
   assign bus.disp_stall        = (state_q != IDLE) | start;
   assign bus.disp_rtn_data_vld = rtn_vld_q;
   assign bus.disp_rtn_data     = rtn_data_q;
   assign bus.core_run          = (state_q == RUNNING) ? mask_q : '0;
   assign bus.aeg_flat          = aeg_q;
   assign bus.csr_rd_ack        = csr_ack_q;
   assign bus.csr_rd_data       = csr_data_q;
endmodule

// File: tb/tb_cae_disp_ctrl.sv
// tb_cae_disp_ctrl: directed self-checking bench for cae_disp_ctrl
module tb_cae_disp_ctrl;
   logic clk = 1'b0;
   logic i_reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   cae_disp_ctrl_if #(.NUM_AEG(8), .NUM_CORES(4), .GVT_W(16)) bus ();
   cae_disp_ctrl #(.NUM_AEG(8), .AEG_IDX_W(3), .NUM_CORES(4), .GVT_W(16)) dut (
      .clk(clk), .i_reset(i_reset), .bus(bus)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic aeg_wr(input logic [17:0] idx, input logic [63:0] d);
      bus.disp_aeg_wr = 1'b1;
      bus.disp_aeg_idx = idx;
      bus.disp_aeg_wr_data = d;
      tick();
      bus.disp_aeg_wr = 1'b0;
   endtask
   task automatic aeg_rd(input string tag, input logic [17:0] idx, input logic [63:0] exp);
      bus.disp_aeg_rd = 1'b1;
      bus.disp_aeg_idx = idx;
      tick();
      bus.disp_aeg_rd = 1'b0;
      chk({tag, "_vld"}, 64'(bus.disp_rtn_data_vld), 64'd1);
      chk(tag, bus.disp_rtn_data, exp);
   endtask
   task automatic csr_rd(input string tag, input logic [15:0] a, input logic [63:0] exp);
      bus.csr_rd_vld = 1'b1;
      bus.csr_address = a;
      tick();
      bus.csr_rd_vld = 1'b0;
      chk({tag, "_ack"}, 64'(bus.csr_rd_ack), 64'd1);
      chk(tag, bus.csr_rd_data, exp);
   endtask
   task automatic inst(input logic [4:0] op);
      bus.disp_inst_vld = 1'b1;
      bus.disp_inst = op;
      tick();
      bus.disp_inst_vld = 1'b0;
   endtask
   initial begin
      bus.disp_inst_vld = 1'b0;
      bus.disp_inst = '0;
      bus.disp_aeg_idx = '0;
      bus.disp_aeg_rd = 1'b0;
      bus.disp_aeg_wr = 1'b0;
      bus.disp_aeg_wr_data = '0;
      bus.core_done = '0;
      bus.core_gvt = '0;
      bus.csr_rd_vld = 1'b0;
      bus.csr_address = '0;
      repeat (2) tick();
      chk("rst_idle", 64'(bus.disp_idle), 64'd1);
      chk("rst_stall", 64'(bus.disp_stall), 64'd0);
      chk("rst_cnt", 64'(bus.disp_aeg_cnt), 64'd8);
      chk("rst_exc", 64'(bus.disp_exception), 64'd0);
      chk("rst_run", 64'(bus.core_run), 64'd0);
      chk("rst_aeg_any", 64'(|bus.aeg_flat), 64'd0);
      chk("rst_rvld", 64'(bus.disp_rtn_data_vld), 64'd0);
      i_reset = 1'b0;
      tick();
      // all four cores complete on different cycles
      aeg_wr(1, 64'hF);
      aeg_wr(2, 64'h0);
      bus.core_gvt = {16'd25, 16'd33, 16'd12, 16'd40};
      bus.disp_inst_vld = 1'b1;
      bus.disp_inst = 5'd0;
      #1;
      chk("t1_stall_pend", 64'(bus.disp_stall), 64'd1);
      chk("t1_idle_pend", 64'(bus.disp_idle), 64'd0);
      tick();
      bus.disp_inst_vld = 1'b0;
      tick();
      chk("t1_run", 64'(bus.core_run), 64'hF);
      bus.core_done = 4'b0001; tick();
      bus.core_done = 4'b0000; tick();
      bus.core_done = 4'b0010; tick();
      bus.core_done = 4'b0100; tick();
      bus.core_done = 4'b1000; tick();
      bus.core_done = 4'b0000;
      chk("t1_run_fin", 64'(bus.core_run), 64'h0);
      tick();
      chk("t1_aeg0", bus.aeg_flat[63:0], 64'd12);
      chk("t1_idle", 64'(bus.disp_idle), 64'd1);
      chk("t1_exc", 64'(bus.disp_exception), 64'd0);
      csr_rd("t1_csr1", 16'h1, 64'd12);
      // mask 0101: unmasked cores ignored
      aeg_wr(1, 64'h5);
      bus.core_gvt = {16'd2, 16'd9, 16'd2, 16'd7};
      inst(5'd0);
      tick();
      chk("t2_run", 64'(bus.core_run), 64'h5);
      bus.core_done = 4'b1111; tick();
      bus.core_done = 4'b0000; tick();
      chk("t2_aeg0", bus.aeg_flat[63:0], 64'd7);
      csr_rd("t2_csr0", 16'h0, 64'h5);
      // cycle-limit timeout with core1 never done
      aeg_wr(2, 64'd100);
      aeg_wr(1, 64'h3);
      bus.core_gvt = {16'd0, 16'd0, 16'd0, 16'd50};
      inst(5'd0);
      tick();
      bus.core_done = 4'b0001; tick();
      bus.core_done = 4'b0000;
      repeat (98) tick();
      chk("t3_exc_pre", 64'(bus.disp_exception), 64'd0);
      chk("t3_run_pre", 64'(bus.core_run), 64'h3);
      tick();
      chk("t3_exc_to", 64'(bus.disp_exception), 64'h8);
      chk("t3_run_to", 64'(bus.core_run), 64'h0);
      tick();
      chk("t3_exc_after", 64'(bus.disp_exception), 64'd0);
      chk("t3_aeg0", bus.aeg_flat[63:0], 64'd50);
      csr_rd("t3_csr2", 16'h2, 64'd100);
      csr_rd("t3_csr0", 16'h0, 64'h1);
      csr_rd("t3_csr7", 16'h7, 64'h0);
      // invalid index, write while running, bad opcode, abort with nothing done
      aeg_wr(8, 64'h1);
      chk("t4_exc_badwr", 64'(bus.disp_exception), 64'h2);
      aeg_wr(3, 64'hDEAD_BEEF_0123_4567);
      aeg_rd("t4_rd3", 3, 64'hDEAD_BEEF_0123_4567);
      tick();
      chk("t4_rvld_drop", 64'(bus.disp_rtn_data_vld), 64'd0);
      aeg_wr(1, 64'h1);
      aeg_wr(2, 64'h0);
      inst(5'd0);
      tick();
      aeg_wr(3, 64'h1111);
      chk("t4_exc_busywr", 64'(bus.disp_exception), 64'h4);
      aeg_rd("t4_rd9", 9, 64'h0);
      chk("t4_exc_badrd", 64'(bus.disp_exception), 64'h2);
      inst(5'd5);
      chk("t4_exc_op", 64'(bus.disp_exception), 64'h1);
      inst(5'd1);
      chk("t4_exc_abort", 64'(bus.disp_exception), 64'h10);
      tick();
      chk("t4_aeg0", bus.aeg_flat[63:0], 64'hFFFF);
      aeg_rd("t4_rd3_keep", 3, 64'hDEAD_BEEF_0123_4567);
      // abort coincident with last done; start while running ignored
      aeg_wr(1, 64'h3);
      bus.core_gvt = {16'd0, 16'd0, 16'd11, 16'd20};
      inst(5'd0);
      tick();
      inst(5'd0);
      chk("t5_exc_restart", 64'(bus.disp_exception), 64'h0);
      chk("t5_run", 64'(bus.core_run), 64'h3);
      bus.core_done = 4'b0001; tick();
      bus.core_done = 4'b0010;
      inst(5'd1);
      bus.core_done = 4'b0000;
      chk("t5_exc_abort", 64'(bus.disp_exception), 64'h10);
      chk("t5_run_drop", 64'(bus.core_run), 64'h0);
      tick();
      chk("t5_aeg0", bus.aeg_flat[63:0], 64'd11);
      // asynchronous reset mid-run, then zero-mask launch
      aeg_wr(1, 64'hF);
      inst(5'd0);
      tick();
      chk("t6_run", 64'(bus.core_run), 64'hF);
      #3 i_reset = 1'b1;
      #1;
      chk("t6_run_async", 64'(bus.core_run), 64'h0);
      chk("t6_aeg_any", 64'(|bus.aeg_flat), 64'd0);
      chk("t6_idle", 64'(bus.disp_idle), 64'd1);
      tick();
      i_reset = 1'b0;
      aeg_wr(0, 64'h1234);
      chk("t6_aeg0_set", bus.aeg_flat[63:0], 64'h1234);
      inst(5'd0);
      tick();
      chk("t6_fin_run", 64'(bus.core_run), 64'h0);
      tick();
      chk("t6_aeg0", bus.aeg_flat[63:0], 64'h0);
      chk("t6_idle_end", 64'(bus.disp_idle), 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
